// File: rtl/three_parallel_serializer.sv
// Serializes three-sample parallel filter blocks into one rounded, saturated
// sample per clock, with a small block FIFO and valid/ready on both sides.
module three_parallel_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15,
  parameter int DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic signed [IN_W-1:0]  din1_i,
  input  logic signed [IN_W-1:0]  din2_i,
  input  logic signed [IN_W-1:0]  din3_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic signed [OUT_W-1:0] dout_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [1:0]              out_phase_o,
  output logic                    out_last_o,
  output logic [15:0]             sat_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Constants are IN_W+1 wide so the rounding add never overflows.
  localparam logic signed [IN_W:0] RND   = $signed((IN_W+1)'(1) << (SHIFT - 1));
  localparam logic signed [IN_W:0] MAX_V = $signed({{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [IN_W:0] MIN_V = $signed({{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}});

  typedef enum logic {
    OREG_EMPTY = 1'b0,
    OREG_FULL  = 1'b1
  } oreg_state_e;

  oreg_state_e             oreg_q, oreg_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [1:0]              rd_phase_q, rd_phase_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;
  logic [1:0]              out_phase_q, out_phase_d;
  logic                    out_last_q, out_last_d;
  logic [15:0]             sat_cnt_q, sat_cnt_d;

  logic                    push, pop, load, consumed, fifo_empty;
  logic [IN_W-1:0]         lane_din [3];
  logic [2:0][OUT_W-1:0]   lane_conv;
  logic [2:0]              lane_clip;
  logic [OUT_W-1:0]        cur_conv;
  logic                    cur_clip;

  assign lane_din[0] = din1_i;
  assign lane_din[1] = din2_i;
  assign lane_din[2] = din3_i;

  assign fifo_empty = (count_q == '0);
  assign in_ready_o = (count_q < CNT_W'(DEPTH));
  assign push       = in_valid_i && in_ready_o;
  assign consumed   = (oreg_q == OREG_FULL) && out_ready_i;
  assign load       = ((oreg_q == OREG_EMPTY) || out_ready_i) && !fifo_empty;
  assign pop        = load && (rd_phase_q == 2'd2);

  // One storage column per lane; every lane of the head entry is converted in
  // parallel and the current phase picks which result gets loaded.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [IN_W-1:0]        mem [DEPTH];
    logic [IN_W-1:0]        head;
    logic signed [IN_W:0]   sum;
    logic signed [IN_W:0]   shr;
    logic                   over, under;

    always_ff @(posedge clk_i) begin
      if (push) begin
        mem[wr_ptr_q] <= lane_din[gi];
      end
    end

    assign head  = mem[rd_ptr_q];
    assign sum   = $signed({head[IN_W-1], head}) + RND;
    assign shr   = sum >>> SHIFT;
    assign over  = (shr > MAX_V);
    assign under = (shr < MIN_V);

    assign lane_clip[gi] = over || under;
    assign lane_conv[gi] = over  ? MAX_V[OUT_W-1:0] :
                           under ? MIN_V[OUT_W-1:0] :
                                   shr[OUT_W-1:0];
  end

  always_comb begin
    cur_conv = lane_conv[0];
    cur_clip = lane_clip[0];
    case (rd_phase_q)
      2'd1:    begin cur_conv = lane_conv[1]; cur_clip = lane_clip[1]; end
      2'd2:    begin cur_conv = lane_conv[2]; cur_clip = lane_clip[2]; end
      default: begin cur_conv = lane_conv[0]; cur_clip = lane_clip[0]; end
    endcase
  end

  always_comb begin
    oreg_d      = oreg_q;
    rd_phase_d  = rd_phase_q;
    dout_d      = dout_q;
    out_phase_d = out_phase_q;
    out_last_d  = out_last_q;
    sat_cnt_d   = sat_cnt_q;

    case (oreg_q)
      OREG_EMPTY: begin
        if (load) begin
          oreg_d = OREG_FULL;
        end
      end
      OREG_FULL: begin
        if (consumed && !load) begin
          oreg_d = OREG_EMPTY;
        end
      end
      default: oreg_d = OREG_EMPTY;
    endcase

    if (load) begin
      dout_d      = cur_conv;
      out_phase_d = rd_phase_q;
      out_last_d  = (rd_phase_q == 2'd2);
      rd_phase_d  = (rd_phase_q == 2'd2) ? 2'd0 : rd_phase_q + 2'd1;
      if (cur_clip && (sat_cnt_q != 16'hFFFF)) begin
        sat_cnt_d = sat_cnt_q + 16'd1;
      end
    end else if (consumed) begin
      // Drained: phase indicators return to idle, dout keeps its last value.
      out_phase_d = 2'd0;
      out_last_d  = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oreg_q      <= OREG_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_phase_q  <= 2'd0;
      dout_q      <= '0;
      out_phase_q <= 2'd0;
      out_last_q  <= 1'b0;
      sat_cnt_q   <= 16'd0;
    end else begin
      oreg_q      <= oreg_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_phase_q  <= rd_phase_d;
      dout_q      <= dout_d;
      out_phase_q <= out_phase_d;
      out_last_q  <= out_last_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign dout_o      = dout_q;
  assign out_valid_o = (oreg_q == OREG_FULL);
  assign out_phase_o = out_phase_q;
  assign out_last_o  = out_last_q;
  assign sat_cnt_o   = sat_cnt_q;

endmodule
